// File: rtl/vcmemarb_2to1.sv
// Two-requester memory arbiter with an in-order read-tag queue that steers responses back.
// Define VCMEMARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module vcmemarb_2to1 #(
    parameter int ADDR_SZ = 8,
    parameter int DATA_SZ = 32,
    parameter int TAGQ_SZ = 2
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               req0_bits_rw,
    input  logic [ADDR_SZ-1:0] req0_bits_addr,
    input  logic [DATA_SZ-1:0] req0_bits_data,
    input  logic               req0_val,
    output logic               req0_rdy,
    output logic [DATA_SZ-1:0] resp0_bits_data,
    output logic               resp0_val,

    input  logic               req1_bits_rw,
    input  logic [ADDR_SZ-1:0] req1_bits_addr,
    input  logic [DATA_SZ-1:0] req1_bits_data,
    input  logic               req1_val,
    output logic               req1_rdy,
    output logic [DATA_SZ-1:0] resp1_bits_data,
    output logic               resp1_val,

    output logic               memreq_bits_rw,
    output logic [ADDR_SZ-1:0] memreq_bits_addr,
    output logic [DATA_SZ-1:0] memreq_bits_data,
    output logic               memreq_val,
    input  logic               memreq_rdy,
    input  logic [DATA_SZ-1:0] memresp_bits_data,
    input  logic               memresp_val
);
    localparam int DEPTH = 1 << TAGQ_SZ;

    logic               win;
    logic               has_win;
    logic               ok;
    logic               fire;
    logic               rd_fire;
    logic               bypass;
    logic               enq;
    logic               deq;
    logic               empty;
    logic               full;
    logic               head;

    logic [DEPTH-1:0]   tags;
    logic [TAGQ_SZ-1:0] wptr;
    logic [TAGQ_SZ-1:0] rptr;
    logic [TAGQ_SZ:0]   count;

    assign has_win = req0_val | req1_val;

`ifdef VCMEMARB_RR_EN
    logic prio;

    // Contention goes to the preferred port; a lone requester always wins.
    assign win = (req0_val & req1_val) ? prio : req1_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            prio <= 1'b0;
        else if (fire)
            prio <= ~win;
    end
`else
    assign win = req1_val & ~req0_val;
`endif

    assign memreq_bits_rw   = win ? req1_bits_rw   : req0_bits_rw;
    assign memreq_bits_addr = win ? req1_bits_addr : req0_bits_addr;
    assign memreq_bits_data = win ? req1_bits_data : req0_bits_data;

    assign empty = (count == '0);
    assign full  = (count == (TAGQ_SZ+1)'(DEPTH));
    assign head  = tags[rptr];

    // Reads need a free tag slot; memresp_val deliberately plays no part here.
    assign ok         = memreq_bits_rw | ~full;
    assign memreq_val = reset_n & has_win & ok;
    assign req0_rdy   = memreq_val & memreq_rdy & ~win;
    assign req1_rdy   = memreq_val & memreq_rdy & win;

    assign fire    = memreq_val & memreq_rdy;
    assign rd_fire = fire & ~memreq_bits_rw;
    assign bypass  = empty & memresp_val & rd_fire;
    assign enq     = rd_fire & ~bypass;
    assign deq     = memresp_val & ~empty;

    // Responses landing on an empty queue with no read in flight are dropped.
    assign resp0_val = reset_n & ((deq & ~head) | (bypass & ~win));
    assign resp1_val = reset_n & ((deq &  head) | (bypass &  win));
    assign resp0_bits_data = memresp_bits_data;
    assign resp1_bits_data = memresp_bits_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tags  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tags[wptr] <= win;
                wptr       <= wptr + 1'b1;
            end
            if (deq)
                rptr <= rptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_vcmemarb_2to1.sv
// Directed scoreboard bench for vcmemarb_2to1: expected memory requests and responses are
// queued as stimulus is issued and checked by a negedge monitor.
module tb_vcmemarb_2to1;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_bits_rw, req1_bits_rw;
    logic [7:0]  req0_bits_addr, req1_bits_addr;
    logic [31:0] req0_bits_data, req1_bits_data;
    logic        req0_val, req1_val, req0_rdy, req1_rdy;
    logic [31:0] resp0_bits_data, resp1_bits_data;
    logic        resp0_val, resp1_val;
    logic        memreq_bits_rw;
    logic [7:0]  memreq_bits_addr;
    logic [31:0] memreq_bits_data;
    logic        memreq_val, memreq_rdy;
    logic [31:0] memresp_bits_data;
    logic        memresp_val;

    int nvec = 0;
    int nmis = 0;
    logic        tb_prio = 1'b0;
    logic [40:0] exp_mreq[$];
    logic [32:0] exp_resp[$];

    vcmemarb_2to1 dut (
        .clk(clk), .reset_n(reset_n),
        .req0_bits_rw(req0_bits_rw), .req0_bits_addr(req0_bits_addr),
        .req0_bits_data(req0_bits_data), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_bits_data(resp0_bits_data), .resp0_val(resp0_val),
        .req1_bits_rw(req1_bits_rw), .req1_bits_addr(req1_bits_addr),
        .req1_bits_data(req1_bits_data), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_bits_data(resp1_bits_data), .resp1_val(resp1_val),
        .memreq_bits_rw(memreq_bits_rw), .memreq_bits_addr(memreq_bits_addr),
        .memreq_bits_data(memreq_bits_data), .memreq_val(memreq_val),
        .memreq_rdy(memreq_rdy), .memresp_bits_data(memresp_bits_data),
        .memresp_val(memresp_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_val = 0; req0_bits_rw = 0; req0_bits_addr = '0; req0_bits_data = '0;
        req1_val = 0; req1_bits_rw = 0; req1_bits_addr = '0; req1_bits_data = '0;
        memreq_rdy = 1; memresp_val = 0; memresp_bits_data = '0;
    endtask

    // Expected grant given both requesters' valids and the bench's own priority tracking.
    function automatic logic exp_win(input logic v0, input logic v1);
`ifdef VCMEMARB_RR_EN
        return (v0 && v1) ? tb_prio : v1;
`else
        return v1 && !v0;
`endif
    endfunction

    task automatic note_fire(input logic w);
        tb_prio = ~w;
    endtask

    // Monitor: every memory-request fire and every response is matched against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (memreq_val && memreq_rdy) begin
                if (exp_mreq.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL mreq_unexpected: got %h expected none",
                             {memreq_bits_rw, memreq_bits_addr, memreq_bits_data});
                end else
                    chk("mreq", {23'd0, memreq_bits_rw, memreq_bits_addr, memreq_bits_data},
                        {23'd0, exp_mreq.pop_front()});
            end
            if (resp0_val && resp1_val) begin
                nvec++; nmis++;
                $display("FAIL resp_both: got resp0_val=1 resp1_val=1 expected one");
            end else if (resp0_val || resp1_val) begin
                if (exp_resp.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL resp_unexpected: got port %0d data %h expected none",
                             resp1_val, memresp_bits_data);
                end else
                    chk("resp", {31'd0, resp1_val, resp1_val ? resp1_bits_data : resp0_bits_data},
                        {31'd0, exp_resp.pop_front()});
            end
        end
    end

    initial begin
        logic w;
        idle();
        reset_n = 0;
        req0_val = 1; memresp_val = 1; memresp_bits_data = 32'h11;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_memreq_val", memreq_val, 0);
        chk("rst_req0_rdy", req0_rdy, 0);
        chk("rst_req1_rdy", req1_rdy, 0);
        chk("rst_resp0_val", resp0_val, 0);
        chk("rst_resp1_val", resp1_val, 0);
        tick();
        idle();
        reset_n = 1;

        // Zero-latency read: response bypasses the empty queue to port 0.
        req0_val = 1; req0_bits_addr = 8'h04; req0_bits_data = 32'h0;
        memresp_val = 1; memresp_bits_data = 32'hDEADBEEF;
        exp_mreq.push_back({1'b0, 8'h04, 32'h0});
        exp_resp.push_back({1'b0, 32'hDEADBEEF});
        #1;
        chk("bypass_resp0_val", resp0_val, 1);
        chk("bypass_resp0_data", resp0_bits_data, 32'hDEADBEEF);
        chk("bypass_resp1_val", resp1_val, 0);
        note_fire(0);
        tick();

        // Stray response: queue must still be empty, so nothing is delivered.
        idle();
        memresp_val = 1; memresp_bits_data = 32'h55;
        #1;
        chk("stray_resp", {resp1_val, resp0_val}, 0);
        tick();

        // Port 1 write: carried through, no tag, no response.
        idle();
        req1_val = 1; req1_bits_rw = 1; req1_bits_addr = 8'h20; req1_bits_data = 32'hCAFEF00D;
        exp_mreq.push_back({1'b1, 8'h20, 32'hCAFEF00D});
        #1;
        chk("wr_req1_rdy", req1_rdy, 1);
        note_fire(1);
        tick();

        // Memory back-pressure: request offered but no ready.
        idle();
        memreq_rdy = 0; req0_val = 1; req0_bits_addr = 8'h33;
        #1;
        chk("bp_memreq_val", memreq_val, 1);
        chk("bp_req0_rdy", req0_rdy, 0);
        tick();

        // Both ports read for 4 cycles; grant order follows the arbitration policy.
        for (int i = 0; i < 4; i++) begin
            idle();
            req0_val = 1; req0_bits_addr = 8'h40 + 8'(i); req0_bits_data = 32'h0A000000 + i;
            req1_val = 1; req1_bits_addr = 8'h80 + 8'(i); req1_bits_data = 32'h0B000000 + i;
            w = exp_win(1, 1);
            if (w) exp_mreq.push_back({1'b0, 8'h80 + 8'(i), 32'h0B000000 + i});
            else   exp_mreq.push_back({1'b0, 8'h40 + 8'(i), 32'h0A000000 + i});
            exp_resp.push_back({w, 32'h1000 + i});
            #1;
            chk("arb_req0_rdy", req0_rdy, !w);
            chk("arb_req1_rdy", req1_rdy, w);
            note_fire(w);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            memresp_val = 1; memresp_bits_data = 32'h1000 + i;
            tick();
        end

        // Fill the queue with 4 port-1 reads.
        for (int i = 0; i < 4; i++) begin
            idle();
            req1_val = 1; req1_bits_addr = 8'hA0 + 8'(i);
            exp_mreq.push_back({1'b0, 8'hA0 + 8'(i), 32'h0});
            exp_resp.push_back({1'b1, 32'h2000 + i});
            note_fire(1);
            tick();
        end
        // Full: 5th read blocked, port 0 write still fires.
        idle();
        req1_val = 1; req1_bits_addr = 8'hA4;
        req0_val = 1; req0_bits_rw = 1; req0_bits_addr = 8'h30; req0_bits_data = 32'h12345678;
        exp_mreq.push_back({1'b1, 8'h30, 32'h12345678});
        #1;
        chk("full_wr_req0_rdy", req0_rdy, 1);
        chk("full_req1_rdy", req1_rdy, 0);
        note_fire(0);
        tick();
        // Response arriving while full does not open rdy in the same cycle.
        idle();
        req1_val = 1; req1_bits_addr = 8'hA4;
        memresp_val = 1; memresp_bits_data = 32'h2000;
        #1;
        chk("full_rdy_no_comb_resp", req1_rdy, 0);
        tick();
        idle();
        req1_val = 1; req1_bits_addr = 8'hA4;
        exp_mreq.push_back({1'b0, 8'hA4, 32'h0});
        exp_resp.push_back({1'b1, 32'h2004});
        #1;
        chk("after_deq_req1_rdy", req1_rdy, 1);
        note_fire(1);
        tick();
        for (int i = 1; i < 5; i++) begin
            idle();
            memresp_val = 1; memresp_bits_data = 32'h2000 + i;
            tick();
        end

        // Three reads outstanding, then asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            idle();
            req0_val = 1; req0_bits_addr = 8'h10 + 8'(i);
            exp_mreq.push_back({1'b0, 8'h10 + 8'(i), 32'h0});
            tick();
        end
        idle();
        req0_val = 1; req1_val = 1;
        #1;
        chk("pre_rst_memreq_val", memreq_val, 1);
        reset_n = 0;
        #1;
        chk("async_rst_outputs", {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val}, 0);
        tb_prio = 0;
        exp_resp.delete();
        tick();
        idle();
        reset_n = 1;
        memresp_val = 1; memresp_bits_data = 32'h77;
        #1;
        chk("post_rst_stray", {resp1_val, resp0_val}, 0);
        tick();

        // Queue empty after reset: a zero-latency read by port 1 bypasses.
        idle();
        req1_val = 1; req1_bits_addr = 8'h5C;
        memresp_val = 1; memresp_bits_data = 32'hBEEF0001;
        exp_mreq.push_back({1'b0, 8'h5C, 32'h0});
        exp_resp.push_back({1'b1, 32'hBEEF0001});
        tick();
        idle();
        tick();

        chk("mreq_queue_drained", exp_mreq.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/vcmemarb_2to1.md
VCMEMARB_2TO1 -- requirements
Module: vcMemArb_2to1

Interface
REQ-001 Parameter ADDR_SZ, default 8, sets the request address width in bits.
REQ-002 Parameter DATA_SZ, default 32, sets the data width in bits.
REQ-003 Parameter TAGQ_SZ, default 2, sets log2 of the outstanding-read tag queue depth (depth 4).
REQ-004 clk  input  1  the single clock; all state samples on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req0_bits_rw / req0_bits_addr / req0_bits_data  input  1 / ADDR_SZ / DATA_SZ  requester 0 request fields (rw: 0=read, 1=write).
REQ-007 req0_val input 1 and req0_rdy output 1  requester 0 request handshake.
REQ-008 resp0_bits_data output DATA_SZ and resp0_val output 1  requester 0 read response, with no back-pressure.
REQ-009 req1_* and resp1_* are identical to REQ-006 to REQ-008 for requester 1.
REQ-010 memreq_bits_rw / memreq_bits_addr / memreq_bits_data  output  1 / ADDR_SZ / DATA_SZ  shared memory request fields.
REQ-011 memreq_val output 1 and memreq_rdy input 1  shared memory request handshake.
REQ-012 memresp_bits_data input DATA_SZ and memresp_val input 1  memory read response, valid for reads only, with no back-pressure.

Function
REQ-013 Grant is combinational: with only one reqN_val high, that port wins; with both high, the arbitration policy (REQ-030/031) decides.
REQ-014 memreq_bits_* SHALL equal the winning port's fields, and memreq_val = winner exists AND (winner is write OR tag queue not full).
REQ-015 reqN_rdy = (port N is winner) AND memreq_rdy AND (write OR tag queue not full); the loser's rdy is 0.
REQ-016 A fire is reqN_val AND reqN_rdy, at most one port per cycle; writes fire with no tag and produce no response.
REQ-017 A read fire enqueues the winner's port id (1 bit) into the in-order tag queue of depth 2^TAGQ_SZ.
REQ-018 memresp_val dequeues the head tag and drives resp[tag]_val=1 and resp[tag]_bits_data=memresp_bits_data in the same cycle (0-cycle routing).
REQ-019 Bypass: if the queue is empty and memresp_val coincides with a read fire (zero-latency memory), the response goes to the current winner and nothing is enqueued.
REQ-020 Full queue: reads are blocked (REQ-015), writes still fire; rdy SHALL NOT depend combinationally on memresp_val.
REQ-021 Empty queue with memresp_val and no coinciding read fire: the response is dropped, both resp_val stay 0, and queue state is unchanged.
REQ-022 Simultaneous enqueue and dequeue on a non-full, non-empty queue keeps the occupancy count unchanged, and pointers wrap modulo depth.
REQ-023 respN_bits_data SHALL equal memresp_bits_data at all times; only respN_val is steered.
REQ-024 Responses return in request order per the memory contract, and no reordering occurs inside the block.

Reset
REQ-025 While reset_n=0: tag queue empty (read/write pointers 0, count 0) and priority pointer 0.
REQ-026 While reset_n=0: memreq_val, req0_rdy, req1_rdy, resp0_val and resp1_val are 0.
REQ-027 Reset asserted mid-operation discards all outstanding tags; responses arriving after reset are handled per REQ-021.
REQ-028 Reset asserts asynchronously, and the first fire is possible on the first rising clk edge after reset_n rises.
REQ-029 No other state exists.

Configuration
REQ-030 With VCMEMARB_RR_EN defined: round-robin arbitration; the priority pointer names the preferred port and, after any fire by port N, becomes 1-N; it holds when there is no fire.
REQ-031 Without VCMEMARB_RR_EN: fixed priority, port 0 always wins, and the priority register is not instantiated.

Verification
REQ-032 Magic 0-latency memory, port 0 reads addr 0x04 holding 0xDEADBEEF -> resp0_val=1, data 0xDEADBEEF the same cycle, resp1_val=0, queue stays empty.
REQ-033 Both ports read every cycle for 8 cycles, RR_EN defined, memory with random delay -> grants alternate 0,1,0,1, and each port receives exactly 4 responses in order.
REQ-034 Same stimulus as REQ-033 without RR_EN -> port 0 receives all 8 grants and req1_rdy stays 0.
REQ-035 memreq_rdy=1, memory withholds responses, port 1 issues 5 reads -> 4 fire, 5th rdy=0; a port 0 write still fires; after 1 response the 5th read fires the following cycle.
REQ-036 reset_n pulled low with 3 reads outstanding -> all outputs 0 immediately, and stray memresp_val after release gives resp0_val=resp1_val=0.
